// File: rtl/bus_arb_pkg.sv
// Shared types, ID field offsets and helper functions for the shared-bus round-robin arbiter.
package bus_arb_pkg;

  typedef enum logic [0:0] {IDLE, XFER} arb_state_e;

  // The destination ID occupies word[bits-ID_MSB : bits-ID_LSB].
  localparam int unsigned ID_MSB = 1;
  localparam int unsigned ID_LSB = 8;
  localparam int unsigned ID_W   = ID_LSB - ID_MSB + 1;

  localparam logic [7:0] BCAST = 8'hFF;

  // Returns {valid, idx}: the first pending index after last, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] pending, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the farthest candidate to the nearest so the nearest pending index wins.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (pending[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] push_mask(input logic [7:0] id, input logic [1:0] src,
                                           input logic [7:0] bcast);
    logic [3:0] mask;
    if (id < 8'd4) begin
      mask = 4'b0001 << id[1:0];
    end else if (id == bcast) begin
      mask = 4'b1111 & ~(4'b0001 << src);
    end else begin
      mask = 4'b0000;
    end
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: combinational rotate-priority pick plus the last-grant pointer.
module rr_arbiter_4
  import bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  logic [1:0] last_q;

  always_comb begin
    {gnt_valid, gnt_idx} = rr_pick(req, last_q);
  end

  // Pointer resets to 3 so driver 0 holds first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 2'd3;
    end else if (advance && gnt_valid) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/bus_rr_arbiter_4drvrs.sv
// Shared-bus sequencer for four drivers: round-robin pop, ID decode, registered push fan-out.
module bus_rr_arbiter_4drvrs
  import bus_arb_pkg::*;
#(
  parameter int unsigned bits      = 256,
  parameter int unsigned drvrs     = 4,
  parameter logic [7:0]  broadcast = BCAST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pndng_drvr_0_bus_0,
  input  logic            pndng_drvr_1_bus_0,
  input  logic            pndng_drvr_2_bus_0,
  input  logic            pndng_drvr_3_bus_0,
  input  logic [bits-1:0] D_pop_drvr_0_bus_0,
  input  logic [bits-1:0] D_pop_drvr_1_bus_0,
  input  logic [bits-1:0] D_pop_drvr_2_bus_0,
  input  logic [bits-1:0] D_pop_drvr_3_bus_0,
  output logic            pop_drvr_0_bus_0,
  output logic            pop_drvr_1_bus_0,
  output logic            pop_drvr_2_bus_0,
  output logic            pop_drvr_3_bus_0,
  output logic            push_drvr_0_bus_0,
  output logic            push_drvr_1_bus_0,
  output logic            push_drvr_2_bus_0,
  output logic            push_drvr_3_bus_0,
  output logic [bits-1:0] D_push_drvr_0_bus_0,
  output logic [bits-1:0] D_push_drvr_1_bus_0,
  output logic [bits-1:0] D_push_drvr_2_bus_0,
  output logic [bits-1:0] D_push_drvr_3_bus_0,
  output logic            err_drop,
  output logic            busy
);

  logic [drvrs-1:0] pndng;
  logic [bits-1:0]  d_pop [drvrs];

  assign pndng    = {pndng_drvr_3_bus_0, pndng_drvr_2_bus_0,
                     pndng_drvr_1_bus_0, pndng_drvr_0_bus_0};
  assign d_pop[0] = D_pop_drvr_0_bus_0;
  assign d_pop[1] = D_pop_drvr_1_bus_0;
  assign d_pop[2] = D_pop_drvr_2_bus_0;
  assign d_pop[3] = D_pop_drvr_3_bus_0;

  arb_state_e state_q, state_d;

  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       grant;

  logic [bits-1:0] sel_word;
  logic [ID_W-1:0] sel_id;

  logic [bits-1:0] data_q, data_d;
  logic [3:0]      pop_q, pop_d;
  logic [3:0]      push_q, push_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  assign grant    = (state_q == IDLE) && gnt_valid;
  assign sel_word = d_pop[gnt_idx];
  assign sel_id   = sel_word[bits-ID_MSB : bits-ID_LSB];

  rr_arbiter_4 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (pndng),
    .advance   (grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = XFER;
      XFER:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are loaded on the grant edge so they are high exactly during XFER.
  always_comb begin
    data_d = data_q;
    pop_d  = 4'b0000;
    push_d = 4'b0000;
    err_d  = 1'b0;
    busy_d = 1'b0;
    if (grant) begin
      data_d = sel_word;
      pop_d  = 4'b0001 << gnt_idx;
      push_d = push_mask(sel_id, gnt_idx, broadcast);
      err_d  = (push_d == 4'b0000);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      pop_q  <= 4'b0000;
      push_q <= 4'b0000;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pop_q  <= pop_d;
      push_q <= push_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign pop_drvr_0_bus_0    = pop_q[0];
  assign pop_drvr_1_bus_0    = pop_q[1];
  assign pop_drvr_2_bus_0    = pop_q[2];
  assign pop_drvr_3_bus_0    = pop_q[3];
  assign push_drvr_0_bus_0   = push_q[0];
  assign push_drvr_1_bus_0   = push_q[1];
  assign push_drvr_2_bus_0   = push_q[2];
  assign push_drvr_3_bus_0   = push_q[3];
  assign D_push_drvr_0_bus_0 = data_q;
  assign D_push_drvr_1_bus_0 = data_q;
  assign D_push_drvr_2_bus_0 = data_q;
  assign D_push_drvr_3_bus_0 = data_q;
  assign err_drop            = err_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_bus_rr_arbiter_4drvrs.sv
// Bench: queue-based transmit FIFO model with a transaction-level round-robin reference.
module tb_bus_rr_arbiter_4drvrs;

  localparam int unsigned BITS = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      pndng;
  logic [BITS-1:0] d_pop [4];
  logic [3:0]      pop;
  logic [3:0]      push;
  logic [BITS-1:0] d_push [4];
  logic            err_drop;
  logic            busy;

  always #5 clk = ~clk;

  bus_rr_arbiter_4drvrs dut (
    .clk                 (clk),
    .reset               (reset),
    .pndng_drvr_0_bus_0  (pndng[0]),
    .pndng_drvr_1_bus_0  (pndng[1]),
    .pndng_drvr_2_bus_0  (pndng[2]),
    .pndng_drvr_3_bus_0  (pndng[3]),
    .D_pop_drvr_0_bus_0  (d_pop[0]),
    .D_pop_drvr_1_bus_0  (d_pop[1]),
    .D_pop_drvr_2_bus_0  (d_pop[2]),
    .D_pop_drvr_3_bus_0  (d_pop[3]),
    .pop_drvr_0_bus_0    (pop[0]),
    .pop_drvr_1_bus_0    (pop[1]),
    .pop_drvr_2_bus_0    (pop[2]),
    .pop_drvr_3_bus_0    (pop[3]),
    .push_drvr_0_bus_0   (push[0]),
    .push_drvr_1_bus_0   (push[1]),
    .push_drvr_2_bus_0   (push[2]),
    .push_drvr_3_bus_0   (push[3]),
    .D_push_drvr_0_bus_0 (d_push[0]),
    .D_push_drvr_1_bus_0 (d_push[1]),
    .D_push_drvr_2_bus_0 (d_push[2]),
    .D_push_drvr_3_bus_0 (d_push[3]),
    .err_drop            (err_drop),
    .busy                (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transmit FIFO contents per driver; the head is what D_pop shows.
  logic [BITS-1:0] txq [4][$];

  // Reference state: one pending transaction at a time, next expected output values.
  int              m_last;
  bit              m_xfer;
  int              m_w;
  logic [3:0]      exp_pop;
  logic [3:0]      exp_push;
  logic            exp_err;
  logic            exp_busy;
  logic [BITS-1:0] exp_data;

  function automatic logic [BITS-1:0] mk_word(input logic [7:0] id);
    logic [BITS-1:0] w;
    for (int i = 0; i < BITS / 32; i++) w[i*32 +: 32] = $urandom;
    w[BITS-1 -: 8] = id;
    return w;
  endfunction

  function automatic logic [7:0] rand_id();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 8'(r);
    if (r < 6) return 8'hFF;
    if (r == 6) return 8'($urandom_range(4, 254));
    return 8'(r % 4);
  endfunction

  task automatic model_reset();
    m_last   = 3;
    m_xfer   = 0;
    exp_pop  = '0;
    exp_push = '0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
    exp_data = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      pndng[i] = (txq[i].size() > 0);
      d_pop[i] = (txq[i].size() > 0) ? txq[i][0] : mk_word(8'($urandom));
    end
  endtask

  task automatic compare_outputs();
    check("pop", BITS'(pop), BITS'(exp_pop));
    check("push", BITS'(push), BITS'(exp_push));
    check("err_drop", BITS'(err_drop), BITS'(exp_err));
    check("busy", BITS'(busy), BITS'(exp_busy));
    for (int i = 0; i < 4; i++) check($sformatf("d_push%0d", i), d_push[i], exp_data);
  endtask

  // Decide what the next clock edge must produce from the words presented now.
  task automatic advance(input bit arrivals);
    if (arrivals) begin
      for (int i = 0; i < 4; i++) begin
        if (txq[i].size() < 4 && $urandom_range(0, 3) == 0) txq[i].push_back(mk_word(rand_id()));
      end
    end
    if (m_xfer) begin
      void'(txq[m_w].pop_front());
      m_xfer   = 0;
      exp_pop  = '0;
      exp_push = '0;
      exp_err  = 1'b0;
      exp_busy = 1'b0;
    end else begin
      int w;
      logic [7:0] id;
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_last + k) % 4;
        if (w < 0 && txq[i].size() > 0) w = i;
      end
      if (w >= 0) begin
        exp_data = txq[w][0];
        id       = exp_data[BITS-1 -: 8];
        exp_pop  = 4'b0001 << w;
        if (id < 8'd4)        exp_push = 4'b0001 << id;
        else if (id == 8'hFF) exp_push = 4'b1111 & ~(4'b0001 << w);
        else                  exp_push = 4'b0000;
        exp_err  = !(id < 8'd4 || id == 8'hFF);
        exp_busy = 1'b1;
        m_xfer   = 1;
        m_w      = w;
        m_last   = w;
      end
    end
    drive();
  endtask

  task automatic cycle(input bit arrivals);
    @(negedge clk);
    compare_outputs();
    advance(arrivals);
  endtask

  initial begin
    logic [BITS-1:0] w2;
    reset = 1'b1;
    model_reset();
    w2 = '0;
    w2[15:0] = 16'hABCD;
    w2[BITS-1 -: 8] = 8'h01;
    txq[0].push_back(mk_word(8'hFF));
    txq[0].push_back(mk_word(8'h02));
    txq[1].push_back(mk_word(8'h03));
    txq[2].push_back(w2);
    txq[3].push_back(mk_word(8'h07));
    drive();

    // Outputs held at zero under reset with every driver pending.
    repeat (3) begin
      @(negedge clk);
      compare_outputs();
    end
    @(negedge clk);
    compare_outputs();
    reset = 1'b0;
    advance(1'b0);
    repeat (12) cycle(1'b0);

    // Grant driver 1 alone, then drivers 1 and 3 together: 3 must win first.
    txq[1].push_back(mk_word(8'h00));
    repeat (4) cycle(1'b0);
    txq[1].push_back(mk_word(8'h02));
    txq[3].push_back(mk_word(8'h01));
    repeat (8) cycle(1'b0);

    // Reset during XFER of driver 2; afterwards driver 1 wins from restored priority.
    txq[1].push_back(mk_word(8'h00));
    txq[2].push_back(mk_word(8'h03));
    cycle(1'b0);
    @(posedge clk);
    #1;
    check("pop_in_xfer", BITS'(pop), BITS'(4'b0100));
    check("push_in_xfer", BITS'(push), BITS'(4'b1000));
    #1 reset = 1'b1;
    #1;
    check("pop_at_reset", BITS'(pop), '0);
    check("push_at_reset", BITS'(push), '0);
    check("busy_at_reset", BITS'(busy), '0);
    model_reset();
    drive();
    @(negedge clk);
    compare_outputs();
    reset = 1'b0;
    advance(1'b0);
    repeat (8) cycle(1'b0);

    repeat (500) cycle(1'b1);
    repeat (40) cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
